weight_buffer_write_controller: RTL and testbench

WEIGHT_BUFFER_WRITE_CONTROLLER -- requirements
Module: weight_buffer_write_controller

---
 rtl/weight_buffer_pkg.sv | 15 +
 rtl/weight_buffer_write_controller.sv | 134 +++++++++++++
 tb/tb_weight_buffer_write_controller.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/weight_buffer_pkg.sv
// Shared types and default sizing for the weight buffer write controller.
package weight_buffer_pkg;

  localparam int DEFAULT_WEIGHT_BANK_BIT_WIDTH       = 64;
  localparam int DEFAULT_WEIGHT_BANK_DEPTH           = 512;
  localparam int DEFAULT_WEIGHT_BUFFER_BANK_COUNT    = 16;
  localparam int DEFAULT_NUMBER_OF_PE_ARRAYS_PER_ROW = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } wbw_state_t;

endpackage

// File: rtl/weight_buffer_write_controller.sv
// Accepts a load descriptor, then streams weight beats into the selected row
// buffers bank by bank and row by row, one registered write per accepted beat.
module weight_buffer_write_controller
  import weight_buffer_pkg::*;
#(
  parameter int WEIGHT_BANK_BIT_WIDTH       = DEFAULT_WEIGHT_BANK_BIT_WIDTH,
  parameter int WEIGHT_BANK_DEPTH           = DEFAULT_WEIGHT_BANK_DEPTH,
  parameter int WEIGHT_BUFFER_BANK_COUNT    = DEFAULT_WEIGHT_BUFFER_BANK_COUNT,
  parameter int NUMBER_OF_PE_ARRAYS_PER_ROW = DEFAULT_NUMBER_OF_PE_ARRAYS_PER_ROW,
  localparam int ADDR_W = $clog2(WEIGHT_BANK_DEPTH)
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   i_cfg_valid,
  output logic                                   o_cfg_ready,
  input  logic [NUMBER_OF_PE_ARRAYS_PER_ROW-1:0] i_cfg_array_mask,
  input  logic [ADDR_W-1:0]                      i_cfg_base_addr,
  input  logic [ADDR_W:0]                        i_cfg_row_count,
  input  logic                                   i_data_valid,
  output logic                                   o_data_ready,
  input  logic [WEIGHT_BANK_BIT_WIDTH-1:0]       i_data,
  output logic [NUMBER_OF_PE_ARRAYS_PER_ROW-1:0] o_weight_memory_en,
  output logic [WEIGHT_BUFFER_BANK_COUNT-1:0]    o_weight_memory_write_enable,
  output logic [ADDR_W-1:0]                      o_weight_memory_bus_address,
  output logic [WEIGHT_BANK_BIT_WIDTH-1:0]       o_weight_memory_data_in,
  output logic                                   o_busy,
  output logic                                   o_done,
  output logic                                   o_error
);

  localparam int BANK_W = (WEIGHT_BUFFER_BANK_COUNT > 1) ? $clog2(WEIGHT_BUFFER_BANK_COUNT) : 1;
  localparam int CHK_W  = ADDR_W + 2;

  wbw_state_t state, state_next;

  logic [NUMBER_OF_PE_ARRAYS_PER_ROW-1:0] mask_q;
  logic [ADDR_W-1:0]                      base_q;
  logic [ADDR_W:0]                        rows_q;
  logic [ADDR_W:0]                        row_idx;
  logic [BANK_W-1:0]                      bank_idx;

  logic                                   cfg_fire;
  logic                                   data_fire;
  logic                                   cfg_bad;
  logic                                   last_bank;
  logic                                   last_beat;
  logic [CHK_W-1:0]                       cfg_end;
  logic [WEIGHT_BUFFER_BANK_COUNT-1:0]    bank_onehot;

  // Handshakes are derived from the state directly to keep the ready outputs
  // out of the combinational next-state path.
  assign cfg_fire  = i_cfg_valid && (state == ST_IDLE);
  assign data_fire = i_data_valid && (state == ST_LOAD);

  // Extra headroom bit so base + row_count cannot wrap during the range check.
  assign cfg_end = CHK_W'(i_cfg_base_addr) + CHK_W'(i_cfg_row_count);
  assign cfg_bad = (i_cfg_row_count == '0) || (i_cfg_array_mask == '0) ||
                   (cfg_end > CHK_W'(WEIGHT_BANK_DEPTH));

  assign last_bank   = (bank_idx == BANK_W'(WEIGHT_BUFFER_BANK_COUNT - 1));
  assign last_beat   = last_bank && (row_idx == rows_q - 1'b1);
  assign bank_onehot = WEIGHT_BUFFER_BANK_COUNT'(1) << bank_idx;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next   = state;
    o_cfg_ready  = 1'b0;
    o_data_ready = 1'b0;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    case (state)
      ST_IDLE: begin
        o_cfg_ready = 1'b1;
        if (cfg_fire && !cfg_bad) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        o_data_ready = 1'b1;
        o_busy       = 1'b1;
        if (data_fire && last_beat) state_next = ST_DONE;
      end
      ST_DONE: begin
        o_busy     = 1'b1;
        o_done     = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q                       <= '0;
      base_q                       <= '0;
      rows_q                       <= '0;
      row_idx                      <= '0;
      bank_idx                     <= '0;
      o_error                      <= 1'b0;
      o_weight_memory_en           <= '0;
      o_weight_memory_write_enable <= '0;
      o_weight_memory_bus_address  <= '0;
      o_weight_memory_data_in      <= '0;
    end else begin
      o_error                      <= cfg_fire && cfg_bad;
      o_weight_memory_en           <= '0;
      o_weight_memory_write_enable <= '0;
      if (cfg_fire) begin
        mask_q   <= i_cfg_array_mask;
        base_q   <= i_cfg_base_addr;
        rows_q   <= i_cfg_row_count;
        row_idx  <= '0;
        bank_idx <= '0;
      end
      if (data_fire) begin
        o_weight_memory_en           <= mask_q;
        o_weight_memory_write_enable <= bank_onehot;
        // The descriptor check guarantees base + row_idx < depth, so the
        // truncated sum equals the full-width one.
        o_weight_memory_bus_address  <= base_q + ADDR_W'(row_idx);
        o_weight_memory_data_in      <= i_data;
        if (last_bank) begin
          bank_idx <= '0;
          row_idx  <= row_idx + 1'b1;
        end else begin
          bank_idx <= bank_idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_weight_buffer_write_controller.sv
// Directed bench for weight_buffer_write_controller: loads, stalls, rejected
// descriptors, cfg held during a load and reset in the middle of a load.
module tb_weight_buffer_write_controller;

  localparam int DW = 64;
  localparam int NM = 3;
  localparam int AW = 9;
  localparam int BC = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [NM-1:0] cfg_mask;
  logic [AW-1:0] cfg_base;
  logic [AW:0]   cfg_rows;
  logic          data_valid;
  logic          data_ready;
  logic [DW-1:0] data;
  logic [NM-1:0] mem_en;
  logic [BC-1:0] mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          busy;
  logic          done;
  logic          error;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int busy_cnt = 0;

  logic [NM-1:0] q_en[$];
  logic [BC-1:0] q_we[$];
  logic [AW-1:0] q_addr[$];
  logic [DW-1:0] q_data[$];
  logic          q_done[$];

  always #5 clk = ~clk;

  weight_buffer_write_controller #(
    .WEIGHT_BANK_BIT_WIDTH      (DW),
    .WEIGHT_BANK_DEPTH          (512),
    .WEIGHT_BUFFER_BANK_COUNT   (BC),
    .NUMBER_OF_PE_ARRAYS_PER_ROW(NM)
  ) dut (
    .clk                         (clk),
    .reset                       (reset),
    .i_cfg_valid                 (cfg_valid),
    .o_cfg_ready                 (cfg_ready),
    .i_cfg_array_mask            (cfg_mask),
    .i_cfg_base_addr             (cfg_base),
    .i_cfg_row_count             (cfg_rows),
    .i_data_valid                (data_valid),
    .o_data_ready                (data_ready),
    .i_data                      (data),
    .o_weight_memory_en          (mem_en),
    .o_weight_memory_write_enable(mem_we),
    .o_weight_memory_bus_address (mem_addr),
    .o_weight_memory_data_in     (mem_data),
    .o_busy                      (busy),
    .o_done                      (done),
    .o_error                     (error)
  );

  // Record every write strobe mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (mem_en != '0 || mem_we != '0) begin
      q_en.push_back(mem_en);
      q_we.push_back(mem_we);
      q_addr.push_back(mem_addr);
      q_data.push_back(mem_data);
      q_done.push_back(done);
    end
    if (done)  done_cnt++;
    if (error) err_cnt++;
    if (busy)  busy_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clear_q();
    q_en.delete(); q_we.delete(); q_addr.delete(); q_data.delete(); q_done.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cfg(input logic [NM-1:0] m, input logic [AW-1:0] b, input logic [AW:0] r);
    cfg_mask  = m;
    cfg_base  = b;
    cfg_rows  = r;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
  endtask

  // Beat k carries dbase + k; stalled beats keep their value until accepted.
  task automatic send_beats(input int n, input bit gaps, input logic [63:0] dbase);
    int got = 0;
    int cyc = 0;
    logic rdy;
    while (got < n && cyc < 2000) begin
      data_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      data       = dbase + 64'(got);
      rdy        = data_ready;
      @(posedge clk);
      if (data_valid && rdy) got++;
      #1;
      cyc++;
    end
    data_valid = 1'b0;
    check("beats_accepted", 64'(got), 64'(n));
  endtask

  task automatic verify_writes(input string tag, input int n, input logic [AW-1:0] base,
                               input logic [NM-1:0] m, input logic [63:0] dbase);
    logic [BC-1:0] one = 1;
    check({tag, "_count"}, 64'(q_we.size()), 64'(n));
    for (int i = 0; i < n && i < q_we.size(); i++) begin
      check({tag, "_we"},   64'(q_we[i]),   64'(one << (i % BC)));
      check({tag, "_addr"}, 64'(q_addr[i]), 64'(base + AW'(i / BC)));
      check({tag, "_en"},   64'(q_en[i]),   64'(m));
      check({tag, "_data"}, q_data[i],      dbase + 64'(i));
      check({tag, "_done"}, 64'(q_done[i]), 64'(i == n - 1));
    end
  endtask

  initial begin
    int d0;
    reset = 1'b1; cfg_valid = 1'b0; cfg_mask = '0; cfg_base = '0; cfg_rows = '0;
    data_valid = 1'b0; data = '0;
    repeat (3) tick();
    reset = 1'b0;

    // Reset state
    check("rst_cfg_ready",  64'(cfg_ready),  64'd1);
    check("rst_data_ready", 64'(data_ready), 64'd0);
    check("rst_busy",       64'(busy),       64'd0);
    check("rst_done",       64'(done),       64'd0);
    check("rst_error",      64'(error),      64'd0);
    check("rst_en",         64'(mem_en),     64'd0);
    check("rst_we",         64'(mem_we),     64'd0);
    check("rst_addr",       64'(mem_addr),   64'd0);
    check("rst_data",       mem_data,        64'd0);
    tick();

    // One row, back-to-back beats
    clear_q();
    d0 = done_cnt;
    send_cfg(3'b001, 9'd0, 10'd1);
    check("t1_busy_load", 64'(busy), 64'd1);
    check("t1_data_ready", 64'(data_ready), 64'd1);
    send_beats(16, 1'b0, 64'hA5A5_0000_0000_0000);
    check("t1_done_pulse", 64'(done), 64'd1);
    check("t1_data_ready_done", 64'(data_ready), 64'd0);
    repeat (3) tick();
    verify_writes("t1", 16, 9'd0, 3'b001, 64'hA5A5_0000_0000_0000);
    check("t1_done_cnt", 64'(done_cnt - d0), 64'd1);
    check("t1_idle_busy", 64'(busy), 64'd0);

    // Two rows ending exactly at the top of the bank, random stalls
    clear_q();
    d0 = done_cnt;
    send_cfg(3'b101, 9'd510, 10'd2);
    send_beats(32, 1'b1, 64'h1234_0000_0000_0100);
    repeat (3) tick();
    verify_writes("t2", 32, 9'd510, 3'b101, 64'h1234_0000_0000_0100);
    check("t2_done_cnt", 64'(done_cnt - d0), 64'd1);

    // Rejected descriptors
    clear_q();
    repeat (2) tick();
    busy_cnt = 0;
    d0 = err_cnt;
    send_cfg(3'b001, 9'd0, 10'd0);
    check("e1_error", 64'(error), 64'd1);
    check("e1_busy", 64'(busy), 64'd0);
    check("e1_cfg_ready", 64'(cfg_ready), 64'd1);
    tick();
    check("e1_error_clr", 64'(error), 64'd0);
    send_cfg(3'b010, 9'd500, 10'd13);
    check("e2_error", 64'(error), 64'd1);
    check("e2_busy", 64'(busy), 64'd0);
    tick();
    check("e2_error_clr", 64'(error), 64'd0);
    send_cfg(3'b000, 9'd4, 10'd1);
    check("e3_error", 64'(error), 64'd1);
    check("e3_busy", 64'(busy), 64'd0);
    repeat (3) tick();
    check("e_err_cnt", 64'(err_cnt - d0), 64'd3);
    check("e_no_writes", 64'(q_we.size()), 64'd0);
    check("e_busy_cnt", 64'(busy_cnt), 64'd0);

    // cfg_valid held high throughout a load
    clear_q();
    cfg_mask = 3'b010; cfg_base = 9'd4; cfg_rows = 10'd1; cfg_valid = 1'b1;
    tick();
    cfg_mask = 3'b100; cfg_base = 9'd100; cfg_rows = 10'd1;
    check("h_cfg_ready_load", 64'(cfg_ready), 64'd0);
    send_beats(16, 1'b0, 64'h0000_0000_0000_2000);
    check("h_done", 64'(done), 64'd1);
    check("h_cfg_ready_done", 64'(cfg_ready), 64'd0);
    tick();
    check("h_cfg_ready_idle", 64'(cfg_ready), 64'd1);
    check("h_busy_idle", 64'(busy), 64'd0);
    tick();
    cfg_valid = 1'b0;
    check("h_busy_reload", 64'(busy), 64'd1);
    verify_writes("h1", 16, 9'd4, 3'b010, 64'h0000_0000_0000_2000);
    clear_q();
    send_beats(16, 1'b0, 64'h0000_0000_0000_3000);
    repeat (3) tick();
    verify_writes("h2", 16, 9'd100, 3'b100, 64'h0000_0000_0000_3000);

    // Reset after beat 7 of a one-row load
    clear_q();
    d0 = done_cnt;
    send_cfg(3'b011, 9'd8, 10'd1);
    send_beats(7, 1'b0, 64'h0000_0000_0000_4000);
    reset = 1'b1;
    data_valid = 1'b1;
    tick();
    check("r_we_after_rst", 64'(mem_we), 64'd0);
    check("r_en_after_rst", 64'(mem_en), 64'd0);
    check("r_busy_after_rst", 64'(busy), 64'd0);
    tick();
    reset = 1'b0;
    data_valid = 1'b0;
    repeat (3) tick();
    check("r_write_count", 64'(q_we.size()), 64'd7);
    check("r_no_done", 64'(done_cnt - d0), 64'd0);
    clear_q();
    send_cfg(3'b001, 9'd20, 10'd1);
    send_beats(16, 1'b0, 64'h0000_0000_0000_5000);
    repeat (3) tick();
    verify_writes("r2", 16, 9'd20, 3'b001, 64'h0000_0000_0000_5000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
